// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that shares one s-selected datapath mux between N requesters.
// A grant is locked until the owner pulses done. Release and re-arbitration can
// happen on the same edge, so back-to-back transfers leave no idle gap.
// Optional build macro ARB_TIMEOUT_EN adds a hold counter that force-releases a
// grant after TIMEOUT cycles. Without the macro, timeout is tied to 0.
module mux_sel_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned SELW    = $clog2(N),
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    localparam logic [N-1:0] OneHot0 = {{(N-1){1'b0}}, 1'b1};

    if (N < 2 || N > 16 || TIMEOUT < 1) begin : g_param_check
        $error("mux_sel_arbiter: N must be 2..16 and TIMEOUT at least 1");
    end

    state_e          state_q;
    logic [N-1:0]    gnt_q;
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] ptr_q;
    logic            busy_q;

    logic            tmo_hit;
    logic            release_now;
    logic [SELW-1:0] nxt_ptr;
    logic [SELW-1:0] scan_start;
    logic [N-1:0]    scan_req;
    logic            found;
    logic [SELW-1:0] win;

    // Owner index plus one, wrapped explicitly so non-power-of-two N stays in range
    assign nxt_ptr     = (sel_q == SELW'(N - 1)) ? '0 : sel_q + SELW'(1);
    assign release_now = (state_q == StOwned) && (done || tmo_hit);

    // One scan serves both cases: from ptr in IDLE, or from the post-release
    // pointer with the outgoing owner masked out
    always_comb begin
        scan_start = ptr_q;
        scan_req   = req;
        if (state_q == StOwned) begin
            scan_start = nxt_ptr;
            scan_req   = req & ~gnt_q;
        end
    end

    // First set request scanning upward from scan_start, modulo N
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(scan_start) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && scan_req[SELW'(idx)]) begin
                found = 1'b1;
                win   = SELW'(idx);
            end
        end
    end

    // Grant FSM: lock on a winner, hold until release, re-arbitrate on release
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q <= StOwned;
                        gnt_q   <= OneHot0 << win;
                        sel_q   <= win;
                        busy_q  <= 1'b1;
                    end
                end
                StOwned: begin
                    if (release_now) begin
                        ptr_q <= nxt_ptr;
                        if (found) begin
                            gnt_q <= OneHot0 << win;
                            sel_q <= win;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    // done wins over the limit, so a coinciding release is a normal one
    assign tmo_hit = (state_q == StOwned) && (cnt_q == CntW'(TIMEOUT - 1)) && !done;

    // Hold counter restarts whenever an ownership is not simply continuing
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= release_now && tmo_hit;
            if (state_q != StOwned || release_now) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter (N=4). The stimulus process queues each expected grant;
// a negedge monitor pops one entry for every new grant it sees and checks the
// gnt/sel/busy invariants every cycle. Timing-sensitive points are checked inline.
module tb_mux_sel_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned SELW = 2;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 64;
`endif

    typedef struct packed {
        logic [N-1:0]    gnt;
        logic [SELW-1:0] sel;
    } exp_t;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] sel;
    logic            busy;
    logic            timeout;

    exp_t         exp_q[$];
    int           n_cmp;
    int           n_err;
    logic [N-1:0] prev_gnt;

    mux_sel_arbiter #(
        .N       (N),
        .SELW    (SELW),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int idx);
        exp_t e;
        logic [N-1:0] one;
        one   = 1;
        e.gnt = one << idx;
        e.sel = SELW'(idx);
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string name, input logic [N-1:0] g, input logic [SELW-1:0] s,
                             input logic b);
        check({name, "_gnt"}, 32'(gnt), 32'(g));
        check({name, "_sel"}, 32'(sel), 32'(s));
        check({name, "_busy"}, 32'(busy), 32'(b));
    endtask

    // Monitor: scoreboard pop on every new grant plus per-cycle invariants
    initial prev_gnt = '0;
    always @(negedge clk) begin
        exp_t e;
        int   idx;
        check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("inv_busy_or", 32'(busy), 32'(|gnt));
        if (busy === 1'b1) begin
            idx = 0;
            for (int i = 0; i < int'(N); i++) begin
                if (gnt[i]) idx = i;
            end
            check("inv_sel_idx", 32'(sel), 32'(idx));
        end
`ifndef ARB_TIMEOUT_EN
        check("inv_timeout_zero", 32'(timeout), 32'd0);
`endif
        if (gnt !== prev_gnt && gnt !== '0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_grant: got gnt=%b sel=%0d, want none", gnt, sel);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant_gnt", 32'(gnt), 32'(e.gnt));
                check("sb_grant_sel", 32'(sel), 32'(e.sel));
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        req     = 4'b1111;
        done    = 1'b0;

        // Reset held for three cycles with every requester asking
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset", 4'b0000, 2'd0, 1'b0);
            check("reset_timeout", 32'(timeout), 32'd0);
        end
        reset_n = 1'b1;
        expect_grant(0);
        tick();
        check_out("first_grant", 4'b0001, 2'd0, 1'b1);

        // Round-robin: done on the 3rd ownership cycle, owners 1,2,3,0 back-to-back
        for (int k = 1; k <= 4; k++) begin
            tick();
            tick();
            done = 1'b1;
            expect_grant(k % 4);
            tick();
            done = 1'b0;
            check("rr_no_gap_busy", 32'(busy), 32'd1);
            check("rr_owner_sel", 32'(sel), 32'(k % 4));
        end

        // Release to idle (ptr becomes 1); sel keeps the last owner
        req  = 4'b0000;
        done = 1'b1;
        tick();
        done = 1'b0;
        check_out("to_idle", 4'b0000, 2'd0, 1'b0);

        // Single requester 2: grant held after req drops, released by done
        req = 4'b0100;
        expect_grant(2);
        tick();
        check_out("single_grant", 4'b0100, 2'd2, 1'b1);
        tick();
        tick();
        req = 4'b0000;
        tick();
        check_out("single_held_c4", 4'b0100, 2'd2, 1'b1);
        tick();
        check_out("single_held_c5", 4'b0100, 2'd2, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_out("single_release", 4'b0000, 2'd2, 1'b0);

        // Wrap from ptr=3 to requester 0, then 1; late req 3 wins after owner 1
        req = 4'b0011;
        expect_grant(0);
        tick();
        check_out("wrap_grant0", 4'b0001, 2'd0, 1'b1);
        done = 1'b1;
        expect_grant(1);
        tick();
        done = 1'b0;
        check_out("wrap_grant1", 4'b0010, 2'd1, 1'b1);
        req = 4'b1011;
        tick();
        check_out("skip_frozen", 4'b0010, 2'd1, 1'b1);
        done = 1'b1;
        expect_grant(3);
        tick();
        check_out("skip_grant3", 4'b1000, 2'd3, 1'b1);
        expect_grant(0);
        tick();
        done = 1'b0;
        check_out("wrap_3_to_0", 4'b0001, 2'd0, 1'b1);

        // Release to idle, then done while idle is ignored
        req  = 4'b0000;
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        check_out("done_in_idle", 4'b0000, 2'd0, 1'b0);

        // Reset mid-grant drops owner 1 and clears ptr
        req = 4'b0010;
        expect_grant(1);
        tick();
        check_out("pre_reset_owner1", 4'b0010, 2'd1, 1'b1);
        req     = 4'b0011;
        reset_n = 1'b0;
        tick();
        check_out("mid_reset", 4'b0000, 2'd0, 1'b0);
        reset_n = 1'b1;
        expect_grant(0);
        tick();
        check_out("post_reset_grant0", 4'b0001, 2'd0, 1'b1);

        // Back to idle with ptr=1
        req  = 4'b0000;
        done = 1'b1;
        tick();
        done = 1'b0;

        // Long hold: forced release after TIMEOUT cycles, or indefinite hold
        req = 4'b0001;
        expect_grant(0);
        tick();
        check_out("hold_grant0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
        expect_grant(1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_out("tmo_held", 4'b0001, 2'd0, 1'b1);
            check("tmo_not_yet", 32'(timeout), 32'd0);
        end
        tick();
        check_out("tmo_handover", 4'b0010, 2'd1, 1'b1);
        check("tmo_pulse", 32'(timeout), 32'd1);
        tick();
        check("tmo_pulse_end", 32'(timeout), 32'd0);
`else
        for (int i = 1; i < 20; i++) begin
            tick();
            check_out("hold_forever", 4'b0001, 2'd0, 1'b1);
        end
        done = 1'b1;
        expect_grant(1);
        tick();
        done = 1'b0;
        check_out("hold_handover", 4'b0010, 2'd1, 1'b1);
`endif
        req  = 4'b0000;
        done = 1'b1;
        tick();
        done = 1'b0;
        check_out("final_idle", 4'b0000, 2'd1, 1'b0);

        tick();
        @(negedge clk);
        #1;
        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
